// File: rtl/uart_cmd_pkg.sv
// Shared command/reply codes and FSM state type for the UART command responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Optional UART_CMD_CHECKSUM_EN adds the GET_CSUM state.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
`ifdef UART_CMD_CHECKSUM_EN
    GET_CSUM,
`endif
    EXEC,
    TX_REQ,
    TX_WAIT
  } state_t;

endpackage

// File: rtl/uart_cmd_responder_if.sv
// Byte link between the UART and the command responder (rx strobe, tx request/busy).
// Latency: wires only.
// Backpressure: tx_busy from the UART holds off the next reply; rx has none (strobes only).
interface uart_cmd_responder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;

  // UART side: produces received bytes and transmitter status
  modport master (
    output rx_data, rx_valid, tx_busy,
    input  tx_data, tx_start
  );

  // Responder side: consumes bytes and requests reply transmission
  modport slave (
    input  rx_data, rx_valid, tx_busy,
    output tx_data, tx_start
  );
endinterface

// File: rtl/uart_cmd_regfile.sv
// NREGS x 8-bit register bank with one write port, combinational read, flat export.
// Latency: write visible on regs/rd_data the cycle after wr_en; read is combinational.
// Backpressure: none; every write strobe is taken.
module uart_cmd_regfile #(
  parameter int NREGS = 16,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [7:0]         wr_data,
  input  logic [AW-1:0]      rd_addr,
  output logic [7:0]         rd_data,
  output logic [NREGS*8-1:0] regs
);

  logic [7:0] mem [NREGS];

  // Storage: cleared on reset, one byte written per strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NREGS; k++) mem[k] <= 8'h00;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: caller guarantees rd_addr is in range before using the value
  assign rd_data = mem[rd_addr];

  // Flat export, register k at regs[8k+7:8k]
  for (genvar k = 0; k < NREGS; k++) begin : g_flat
    assign regs[8*k +: 8] = mem[k];
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// Decodes W/R byte frames from the UART into register bank accesses, one reply byte per frame.
// Latency: EXEC the cycle after the last frame byte; tx_start and reg_wr one cycle after EXEC.
// Backpressure: bytes arriving while a reply is pending are dropped (err_drop); tx waits on tx_busy.
// Build option: UART_CMD_CHECKSUM_EN appends an XOR checksum byte to every known-command frame.
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int NREGS          = 16,
  parameter int TIMEOUT_CYCLES = 120000
) (
  input  logic               clk,
  input  logic               rst,
  uart_cmd_responder_if.slave uart,
  output logic [NREGS*8-1:0] regs,
  output logic               reg_wr,
  output logic [7:0]         reg_wr_addr,
  output logic               err_drop
);

  localparam int AW = $clog2(NREGS);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // State reached after the last payload byte of a known command
`ifdef UART_CMD_CHECKSUM_EN
  localparam state_t LAST_STATE = GET_CSUM;
`else
  localparam state_t LAST_STATE = EXEC;
`endif

  state_t        state, state_d;
  logic [7:0]    cmd_q, addr_q, data_q;
  logic          bad_cmd_q;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    rd_data, reply, tx_data_q;
  logic          in_get, tmo_hit, is_wr, addr_ok, frame_ok, do_wr, known_cmd;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]    csum_q;
  logic          csum_ok;
`endif

  assign known_cmd = (uart.rx_data == CMD_WR) || (uart.rx_data == CMD_RD);
  assign in_get    = (state == GET_ADDR) || (state == GET_DATA)
`ifdef UART_CMD_CHECKSUM_EN
                   || (state == GET_CSUM)
`endif
                   ;
  // An arriving byte wins over an expiring timeout on the same cycle
  assign tmo_hit   = in_get && !uart.rx_valid && (tmo_cnt >= TW'(TIMEOUT_CYCLES));
  assign is_wr     = (cmd_q == CMD_WR);
  assign addr_ok   = ({1'b0, addr_q} < 9'(NREGS));
`ifdef UART_CMD_CHECKSUM_EN
  // data_q is zeroed at command time, so a read frame folds in a zero data byte
  assign csum_ok   = ((cmd_q ^ addr_q ^ data_q) == csum_q);
  assign frame_ok  = !bad_cmd_q && csum_ok && addr_ok;
`else
  assign frame_ok  = !bad_cmd_q && addr_ok;
`endif
  assign do_wr     = (state == EXEC) && is_wr && frame_ok;
  assign reply     = !frame_ok ? RSP_NAK : (is_wr ? RSP_ACK : rd_data);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state;
    case (state)
      IDLE:     if (uart.rx_valid) state_d = known_cmd ? GET_ADDR : EXEC;
      GET_ADDR: if (uart.rx_valid) state_d = is_wr ? GET_DATA : LAST_STATE;
                else if (tmo_hit)  state_d = IDLE;
      GET_DATA: if (uart.rx_valid) state_d = LAST_STATE;
                else if (tmo_hit)  state_d = IDLE;
`ifdef UART_CMD_CHECKSUM_EN
      GET_CSUM: if (uart.rx_valid) state_d = EXEC;
                else if (tmo_hit)  state_d = IDLE;
`endif
      EXEC:     state_d = TX_REQ;
      TX_REQ:   if (uart.tx_busy)  state_d = TX_WAIT;
      TX_WAIT:  if (!uart.tx_busy) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Frame byte capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_q     <= 8'h00;
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
      bad_cmd_q <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
      csum_q    <= 8'h00;
`endif
    end else if (uart.rx_valid) begin
      case (state)
        IDLE: begin
          cmd_q     <= uart.rx_data;
          bad_cmd_q <= !known_cmd;
          data_q    <= 8'h00;
        end
        GET_ADDR: addr_q <= uart.rx_data;
        GET_DATA: data_q <= uart.rx_data;
`ifdef UART_CMD_CHECKSUM_EN
        GET_CSUM: csum_q <= uart.rx_data;
`endif
        default: ;
      endcase
    end
  end

  // Inter-byte timeout: cleared on each byte and outside GET_*, saturating
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          tmo_cnt <= '0;
    else if (!in_get || uart.rx_valid) tmo_cnt <= '0;
    else if (tmo_cnt != '1)            tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Registered side outputs: reply byte, write notification, drop pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_data_q   <= 8'h00;
      reg_wr      <= 1'b0;
      reg_wr_addr <= 8'h00;
      err_drop    <= 1'b0;
    end else begin
      if (state == EXEC) tx_data_q <= reply;
      reg_wr <= do_wr;
      if (do_wr) reg_wr_addr <= addr_q;
      err_drop <= uart.rx_valid &&
                  ((state == EXEC) || (state == TX_REQ) || (state == TX_WAIT));
    end
  end

  // tx_start follows the state directly so reset removes it at once
  assign uart.tx_start = (state == TX_REQ);
  assign uart.tx_data  = tx_data_q;

  uart_cmd_regfile #(.NREGS(NREGS), .AW(AW)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (do_wr),
    .wr_addr (addr_q[AW-1:0]),
    .wr_data (data_q),
    .rd_addr (addr_q[AW-1:0]),
    .rd_data (rd_data),
    .regs    (regs)
  );

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Scoreboard bench for uart_cmd_responder: frames driven with expected replies/writes queued.
// Latency: replies captured when the UART model accepts tx_start.
// Backpressure: UART model holds tx_busy for a fixed time; acceptance delay is adjustable.
module tb_uart_cmd_responder;
  import uart_cmd_pkg::*;

  localparam int NR       = 16;
  localparam int TMO      = 300;
  localparam int BUSY_LEN = 8;
`ifdef UART_CMD_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_cmd_responder_if u ();
  logic [NR*8-1:0] regs;
  logic            reg_wr;
  logic [7:0]      reg_wr_addr;
  logic            err_drop;

  uart_cmd_responder #(.NREGS(NR), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .uart        (u),
    .regs        (regs),
    .reg_wr      (reg_wr),
    .reg_wr_addr (reg_wr_addr),
    .err_drop    (err_drop)
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] wr_q[$];
  logic [7:0]  mdl[NR];
  int          drops = 0;
  int          accept_dly = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NR*8-1:0] mdl_flat();
    logic [NR*8-1:0] r;
    for (int k = 0; k < NR; k++) r[8*k +: 8] = mdl[k];
    return r;
  endfunction

  // UART model and output monitors, all sampled on the falling edge
  initial begin
    int busy_cnt;
    int acc_cnt;
    logic [15:0] w;
    logic [7:0]  e;
    busy_cnt  = 0;
    acc_cnt   = 0;
    u.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (reg_wr) begin
        if (wr_q.size() == 0) chk("wr_unexpected", 0, 1);
        else begin
          w = wr_q.pop_front();
          chk("wr_addr", reg_wr_addr, w[15:8]);
          chk("wr_data", regs[8*w[15:8] +: 8], w[7:0]);
        end
      end
      if (err_drop) drops++;
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) u.tx_busy = 1'b0;
      end else if (u.tx_start) begin
        if (acc_cnt >= accept_dly) begin
          if (exp_q.size() == 0) chk($sformatf("tx_unexpected_%02h", u.tx_data), 0, 1);
          else begin
            e = exp_q.pop_front();
            chk("tx_reply", u.tx_data, e);
          end
          u.tx_busy = 1'b1;
          busy_cnt  = BUSY_LEN;
          acc_cnt   = 0;
        end else acc_cnt++;
      end else acc_cnt = 0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    u.rx_data  = b;
    u.rx_valid = 1'b1;
    @(negedge clk);
    u.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && wr_q.size() == 0 && !u.tx_busy && !u.tx_start) begin
        done = 1'b1;
        break;
      end
    end
    chk(tag, done, 1);
  endtask

  task automatic send_wr_bytes(input logic [7:0] a, input logic [7:0] d, input bit bad_cs);
    send_byte(CMD_WR);
    send_byte(a);
    send_byte(d);
    if (CS_EN) send_byte(bad_cs ? 8'h00 : (CMD_WR ^ a ^ d));
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d, input bit bad_cs);
    if (!(CS_EN && bad_cs) && a < NR) begin
      exp_q.push_back(RSP_ACK);
      wr_q.push_back({a, d});
      mdl[a] = d;
    end else exp_q.push_back(RSP_NAK);
  endtask

  task automatic do_wr(input logic [7:0] a, input logic [7:0] d, input bit bad_cs);
    push_wr(a, d, bad_cs);
    send_wr_bytes(a, d, bad_cs);
    wait_idle("wr_done");
  endtask

  task automatic do_rd(input logic [7:0] a);
    exp_q.push_back(a < NR ? mdl[a] : RSP_NAK);
    send_byte(CMD_RD);
    send_byte(a);
    if (CS_EN) send_byte(CMD_RD ^ a);
    wait_idle("rd_done");
  endtask

  initial begin
    bit seen;
    int d0;
    logic [7:0] ra, rd;
    for (int k = 0; k < NR; k++) mdl[k] = 8'h00;
    u.rx_data  = 8'h00;
    u.rx_valid = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_regs", regs, '0);
    chk("rst_tx_start", u.tx_start, 0);
    chk("rst_tx_data", u.tx_data, 0);
    chk("rst_reg_wr", reg_wr, 0);
    chk("rst_reg_wr_addr", reg_wr_addr, 0);
    chk("rst_err_drop", err_drop, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    do_rd(8'h07);
    do_wr(8'h03, 8'hA5, 1'b0);
    chk("reg3", regs[31:24], 8'hA5);
    do_rd(8'h03);

    // Unknown command
    exp_q.push_back(RSP_NAK);
    send_byte(8'h41);
    wait_idle("nak_done");
    do_rd(8'h03);

    // Out-of-range write
    do_wr(8'h10, 8'hFF, 1'b0);
    chk("oor_regs", regs, mdl_flat());
    do_rd(8'hFF);

    // Partial frame abandoned by timeout
    send_byte(CMD_WR);
    send_byte(8'h02);
    repeat (TMO + 20) @(negedge clk);
    chk("tmo_regs", regs, mdl_flat());
    do_rd(8'h02);

    // Boundary and random accesses
    do_wr(8'(NR - 1), 8'h5A, 1'b0);
    do_rd(8'(NR - 1));
    do_wr(8'h00, 8'hC3, 1'b0);
    do_rd(8'h00);
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom_range(0, NR - 1));
      rd = 8'($urandom);
      do_wr(ra, rd, 1'b0);
      do_rd(ra);
    end
    chk("rand_regs", regs, mdl_flat());

    // Byte arriving while the reply is being sent is dropped
    d0 = drops;
    push_wr(8'h04, 8'h77, 1'b0);
    send_wr_bytes(8'h04, 8'h77, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (u.tx_busy) begin seen = 1'b1; break; end
    end
    chk("busy_seen", seen, 1);
    send_byte(8'h41);
    wait_idle("drop_done");
    chk("err_drop_cnt", drops, d0 + 1);
    chk("drop_regs", regs, mdl_flat());

`ifdef UART_CMD_CHECKSUM_EN
    do_wr(8'h01, 8'h3C, 1'b0);
    chk("cs_reg1", regs[15:8], 8'h3C);
    do_wr(8'h01, 8'h99, 1'b1);
    chk("cs_bad_reg1", regs[15:8], 8'h3C);
    do_rd(8'h01);
`endif

    // Reset while the reply is waiting for acceptance
    accept_dly = 30;
    push_wr(8'h05, 8'h11, 1'b0);
    send_wr_bytes(8'h05, 8'h11, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (u.tx_start) begin seen = 1'b1; break; end
    end
    chk("tx_req_seen", seen, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_tx_start", u.tx_start, 0);
    chk("mid_rst_regs", regs, '0);
    chk("mid_rst_tx_data", u.tx_data, 0);
    chk("mid_rst_reg_wr", reg_wr, 0);
    chk("mid_rst_reg_wr_addr", reg_wr_addr, 0);
    chk("mid_rst_err_drop", err_drop, 0);
    chk("mid_rst_wr_popped", wr_q.size(), 0);
    exp_q.delete();
    for (int k = 0; k < NR; k++) mdl[k] = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    accept_dly = 0;
    repeat (2) @(negedge clk);
    do_rd(8'h05);
    do_rd(8'h03);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_responder.md
# uart_cmd_responder

Byte-level command responder for the far end of the UART link. Consumes received bytes from `uart` (`rx_data`/`rx_valid`) and decodes host read/write frames against a local 8-bit register bank. Returns one reply byte per frame through the `uart` transmitter (`tx_data`/`tx_start`/`tx_busy`). Sits between `uart` and the user logic that consumes the exported registers.

## Interface
- `NREGS`, 16: number of 8-bit registers; must be 2..256.
- `TIMEOUT_CYCLES`, 120000: maximum idle clk cycles between bytes of one frame (10 ms at 12 MHz).
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `rx_data` in 8: received byte, valid when `rx_valid`.
- `rx_valid` in 1: one-cycle strobe per received byte.
- `tx_data` out 8: reply byte; held stable while `tx_start` is high.
- `tx_start` out 1: request to send `tx_data`.
- `tx_busy` in 1: transmitter is shifting.
- `regs` out NREGS*8: flat register bank; register k occupies `regs[8k+7:8k]`.
- `reg_wr` out 1: one-cycle pulse when a register is written.
- `reg_wr_addr` out 8: address of the write; valid with `reg_wr`.
- `err_drop` out 1: one-cycle pulse when a received byte is discarded.

## Operation
- Frames (bytes):
  - Write: 0x57 ('W'), addr, data. Reply 0x06 (ACK).
  - Read: 0x52 ('R'), addr. Reply is the register value.
- First byte not 0x57 or 0x52: reply 0x15 (NAK) and return to IDLE.
- addr ≥ NREGS: NAK, no write. The frame is still fully consumed; a write frame still takes its data byte.
- FSM states: IDLE → GET_ADDR → [GET_DATA] → [GET_CSUM] → EXEC → TX_REQ → TX_WAIT → IDLE.
  - IDLE, on `rx_valid`: latch the command byte. Go to GET_ADDR, or to EXEC with NAK for an unknown command.
  - GET_ADDR: on `rx_valid`, latch addr. Next state is GET_DATA for a write, else GET_CSUM or EXEC.
  - GET_DATA: on `rx_valid`, latch data.
  - EXEC (one cycle): perform the write or read and select the reply byte.
  - TX_REQ: hold `tx_start`=1 until `tx_busy`=1, then drop `tx_start`.
  - TX_WAIT: wait for `tx_busy`=0, then go to IDLE.
- Timeout counter: cleared on every accepted byte and increments in GET_* states. When it reaches TIMEOUT_CYCLES, the partial frame is abandoned silently (no reply) and the FSM returns to IDLE.
- Half-duplex: `rx_valid` in EXEC, TX_REQ or TX_WAIT discards the byte and pulses `err_drop`.
- Reset mid-frame or mid-reply: FSM goes to IDLE, `tx_start` drops immediately, and the partial frame is lost.

## Timing
- Reset values: `regs`=0, `tx_start`=0, `tx_data`=0, `reg_wr`=0, `reg_wr_addr`=0, `err_drop`=0. FSM is in IDLE with the timeout counter at 0.
- EXEC is entered on the cycle after the final byte's `rx_valid`.
- In EXEC, on the clock edge, a write updates `regs`. `reg_wr` and `reg_wr_addr` are registered and valid during the cycle after EXEC, which is the first TX_REQ cycle.
- `tx_start` rises one cycle after EXEC.
- A read returns the register value as of the EXEC cycle.
- A write and a read to the same address in back-to-back frames: the read returns the new value.
- `tx_busy` already high when TX_REQ is entered: treated as acceptance, so the FSM proceeds straight to TX_WAIT.
- Timeout comparison is ≥ TIMEOUT_CYCLES. The counter is `$clog2(TIMEOUT_CYCLES+1)` bits wide and saturates, never wrapping.

## Configuration
- `UART_CMD_CHECKSUM_EN` defined:
  - Every frame carries a trailing checksum byte equal to the XOR of all preceding frame bytes.
  - It is received in GET_CSUM, before EXEC.
  - Mismatch → NAK with no write, evaluated before the range check.
  - Unknown commands are NAK'd immediately; no checksum byte is awaited.
- Not defined: GET_CSUM state and its logic are absent, and frames are exactly as listed above.

## Structure
- Package `uart_cmd_pkg`:
  - Command codes `CMD_WR`=8'h57, `CMD_RD`=8'h52.
  - Reply codes `RSP_ACK`=8'h06, `RSP_NAK`=8'h15.
  - FSM state enum type.
- Sub-module `uart_cmd_regfile`: NREGS×8 bank with write port, combinational read port and flat `regs` output. Instantiated once.

## Test plan
- Write: bytes 57 03 A5 → `reg_wr` pulse with `reg_wr_addr`=3; `regs[31:24]`=A5; reply 06.
- Readback: after the write, bytes 52 03 → reply A5. Reading addr 7 after reset → reply 00.
- Bad frames:
  - 41 → reply 15, FSM in IDLE.
  - 57 10 FF with NREGS=16 → reply 15, no `reg_wr`, `regs` unchanged.
- Timeout: 57 02, then idle for TIMEOUT_CYCLES → no reply. Then 52 02 → reply 00.
- Overlap and reset:
  - Inject a byte while `tx_busy`=1 → `err_drop` pulse, byte ignored.
  - Assert `rst` while in TX_REQ → `tx_start`=0 immediately and all outputs at reset values.
- With `UART_CMD_CHECKSUM_EN`:
  - 57 01 3C 6A (57^01^3C) → ACK, reg1=3C.
  - 57 01 3C 00 → NAK, reg1 unchanged.
